// File: rtl/video_edge_blend.sv
// Edge-blend stage for multi-projector overlap: a linear gain ramp on the left/right edge of each
// active line, three register stages from rec_* to tra_*, syncs and DE delayed to match.
module video_edge_blend #(
   parameter int BLEND_LOG2 = 8,
   parameter int CNT_W      = 12
) (
   input  logic             rec_clk,
   input  logic             nreset,
   input  logic [7:0]       rec_red,
   input  logic [7:0]       rec_green,
   input  logic [7:0]       rec_blue,
   input  logic             rec_hsync,
   input  logic             rec_vsync,
   input  logic             rec_de,
   input  logic             blend_left_en,
   input  logic             blend_right_en,
   output logic [7:0]       tra_red,
   output logic [7:0]       tra_green,
   output logic [7:0]       tra_blue,
   output logic             tra_hsync,
   output logic             tra_vsync,
   output logic             tra_de,
   output logic             tra_clk,
   output logic [CNT_W-1:0] line_len,
   output logic             line_len_valid
);

   localparam int GW = BLEND_LOG2 + 1;
   localparam int DW = CNT_W + 2;
   localparam logic [GW-1:0]        GAIN_FULL = {1'b1, {BLEND_LOG2{1'b0}}};
   localparam logic signed [DW-1:0] RAMP_W    = DW'(1 << BLEND_LOG2);
   localparam logic signed [DW-1:0] D_ONE     = DW'(1);
   localparam logic [CNT_W-1:0]     X_MAX     = '1;

   assign tra_clk = rec_clk;

   logic             s1_hs_reg, s1_vs_reg, s1_de_reg;
   logic [CNT_W-1:0] x_reg;
   logic [CNT_W-1:0] x_inc;
   logic             lat_l_reg, lat_r_reg;
   logic             s2_hs_reg, s2_vs_reg, s2_de_reg;
   logic [GW-1:0]    s2_gain_reg;

   logic [GW-1:0]        gl, gr, gain_next;
   logic signed [DW-1:0] d_raw, d_clip;

   logic [2:0][7:0] rec_pix;
   logic [2:0][7:0] out_pix;

   assign rec_pix = {rec_blue, rec_green, rec_red};
   assign x_inc   = (x_reg == X_MAX) ? X_MAX : x_reg + CNT_W'(1);

   // S1: sync/DE capture, pixel position, line length and frame-synchronous enables
   always_ff @(posedge rec_clk or negedge nreset) begin
      if (!nreset) begin
         s1_hs_reg      <= 1'b0;
         s1_vs_reg      <= 1'b0;
         s1_de_reg      <= 1'b0;
         x_reg          <= '0;
         line_len       <= '0;
         line_len_valid <= 1'b0;
         lat_l_reg      <= 1'b0;
         lat_r_reg      <= 1'b0;
      end else begin
         s1_hs_reg <= rec_hsync;
         s1_vs_reg <= rec_vsync;
         s1_de_reg <= rec_de;
         if (rec_de) begin
            x_reg <= s1_de_reg ? x_inc : '0;
         end
         // x_reg still holds the last pixel of the line on the DE falling edge
         if (s1_de_reg && !rec_de) begin
            line_len       <= x_inc;
            line_len_valid <= 1'b1;
         end
         if (rec_vsync && !s1_vs_reg) begin
            lat_l_reg <= blend_left_en;
            lat_r_reg <= blend_right_en;
         end
      end
   end

   // Gain for the pixel in S1; the right ramp counts down to the previous line's last pixel
   always_comb begin
      gl = GAIN_FULL;
      if (lat_l_reg && ($signed({2'b00, x_reg}) < RAMP_W)) begin
         gl = x_reg[GW-1:0] + GW'(1);
      end
      d_raw  = $signed({2'b00, line_len}) - $signed({2'b00, x_reg}) - D_ONE;
      d_clip = d_raw[DW-1] ? '0 : d_raw;
      gr = GAIN_FULL;
      if (lat_r_reg && line_len_valid && (d_clip < RAMP_W)) begin
         gr = d_clip[GW-1:0] + GW'(1);
      end
      gain_next = (gl < gr) ? gl : gr;
   end

   // S2 carries the gain, S3 is the output register
   always_ff @(posedge rec_clk or negedge nreset) begin
      if (!nreset) begin
         s2_hs_reg   <= 1'b0;
         s2_vs_reg   <= 1'b0;
         s2_de_reg   <= 1'b0;
         s2_gain_reg <= '0;
         tra_hsync   <= 1'b0;
         tra_vsync   <= 1'b0;
         tra_de      <= 1'b0;
      end else begin
         s2_hs_reg   <= s1_hs_reg;
         s2_vs_reg   <= s1_vs_reg;
         s2_de_reg   <= s1_de_reg;
         s2_gain_reg <= gain_next;
         tra_hsync   <= s2_hs_reg;
         tra_vsync   <= s2_vs_reg;
         tra_de      <= s2_de_reg;
      end
   end

   for (genvar gi = 0; gi < 3; gi++) begin : gen_ch
      logic [7:0]      s1_pix_reg, s2_pix_reg, out_pix_reg;
      logic [8+GW-1:0] prod;

      // gain <= 2^BLEND_LOG2, so the shifted product never exceeds 255
      assign prod = {{GW{1'b0}}, s2_pix_reg} * {8'd0, s2_gain_reg};

      always_ff @(posedge rec_clk or negedge nreset) begin
         if (!nreset) begin
            s1_pix_reg  <= '0;
            s2_pix_reg  <= '0;
            out_pix_reg <= '0;
         end else begin
            s1_pix_reg  <= rec_pix[gi];
            s2_pix_reg  <= s1_pix_reg;
            out_pix_reg <= s2_de_reg ? 8'(prod >> BLEND_LOG2) : 8'd0;
         end
      end

      assign out_pix[gi] = out_pix_reg;
   end

   assign tra_red   = out_pix[0];
   assign tra_green = out_pix[1];
   assign tra_blue  = out_pix[2];

endmodule
